// File: rtl/maria_lram_pkg.sv
// maria_lram_pkg
//   Shared types, default sizes and helpers for the banked line RAM.
//   - lram_code_t : packed {pal, idx} pixel code at the default widths
//   - DEF_*       : default parameter values used by maria_lram_banked
//   - PTR_W       : bank pointer width (enough for up to 4 banks)
//   - bank_inc()  : bank pointer increment, wrapping at num_banks
package maria_lram_pkg;

   localparam int DEF_NUM_BANKS = 2;
   localparam int DEF_LINE_W    = 320;
   localparam int DEF_PIX_W     = 2;
   localparam int DEF_PAL_W     = 3;
   localparam int PTR_W         = 2;

   typedef struct packed {
      logic [DEF_PAL_W-1:0] pal;
      logic [DEF_PIX_W-1:0] idx;
   } lram_code_t;

   function automatic logic [PTR_W-1:0] bank_inc(input logic [PTR_W-1:0] ptr,
                                                 input int               num_banks);
      if (int'(ptr) >= num_banks - 1)
         return '0;
      else
         return ptr + 1'b1;
   endfunction

endpackage

// File: rtl/maria_lram_bank.sv
// maria_lram_bank
//   One line buffer: LINE_W entries of CODE_W bits plus a per-column valid
//   bitmap, so unwritten or consumed columns read back as zero without a
//   clear sweep over the storage itself.
//   Optional feature macro: MARIA_LRAM_COLLISION_EN (adds wr_old peek port).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears valid bitmap)
//   clr_all     invalidate the whole line (bank released from display)
//   we/wcol/wdata  write port; wcol >= LINE_W is ignored
//   wr_old      current code at wcol (collision build only)
//   re/rcol     read-and-clear port; rcol >= LINE_W reads 0, clears nothing
//   rdata       combinational code at rcol (0 when invalid)
module maria_lram_bank #(
   parameter  int LINE_W = 320,
   parameter  int CODE_W = 5,
   localparam int COL_W  = $clog2(LINE_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_all,
   input  logic              we,
   input  logic [COL_W-1:0]  wcol,
   input  logic [CODE_W-1:0] wdata,
`ifdef MARIA_LRAM_COLLISION_EN
   output logic [CODE_W-1:0] wr_old,
`endif
   input  logic              re,
   input  logic [COL_W-1:0]  rcol,
   output logic [CODE_W-1:0] rdata
);

   localparam logic [COL_W:0] LINE_W_C = (COL_W+1)'(LINE_W);

   logic [CODE_W-1:0] mem [LINE_W];
   logic [LINE_W-1:0] valid;
   logic              wr_in;
   logic              rd_in;

   assign wr_in = ({1'b0, wcol} < LINE_W_C);
   assign rd_in = ({1'b0, rcol} < LINE_W_C);

   assign rdata = (rd_in && valid[rcol]) ? mem[rcol] : '0;

`ifdef MARIA_LRAM_COLLISION_EN
   assign wr_old = (wr_in && valid[wcol]) ? mem[wcol] : '0;
`endif

   // A write in the same cycle as clr_all survives; the later assignment wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else begin
         if (clr_all)
            valid <= '0;
         else if (re && rd_in)
            valid[rcol] <= 1'b0;
         if (we && wr_in)
            valid[wcol] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we && wr_in)
         mem[wcol] <= wdata;
   end

endmodule

// File: rtl/maria_lram_banked.sv
// maria_lram_banked
//   NUM_BANKS line buffers cycled through a completed-line queue. DMA fills
//   the bank at wr_ptr; video plays back the bank at rd_ptr with
//   read-and-clear. Output is the raw {pal, idx} code, registered.
//   Optional feature macro: MARIA_LRAM_COLLISION_EN (collide, collide_line).
// Ports:
//   sysclk, reset_b      clock, asynchronous active-low reset
//   wr_en, wr_col, wr_pal, wr_idx, kangaroo  pixel write (idx 0 skipped
//                        unless kangaroo)
//   wr_line_done         commit the write bank to the queue
//   wr_ready             a free bank is available for writing
//   line_start           start of a displayed line (advance or underflow)
//   rd_col, rd_code      playback column, registered code one cycle later
//   underflow, clr_underflow  sticky empty-queue flag and its clear
//   collide, collide_line     (optional) sticky overlap flag, commit pulse
module maria_lram_banked
   import maria_lram_pkg::*;
#(
   parameter  int NUM_BANKS = DEF_NUM_BANKS,
   parameter  int LINE_W    = DEF_LINE_W,
   parameter  int PIX_W     = DEF_PIX_W,
   parameter  int PAL_W     = DEF_PAL_W,
   localparam int COL_W     = $clog2(LINE_W),
   localparam int CODE_W    = PAL_W + PIX_W
) (
   input  logic              sysclk,
   input  logic              reset_b,
   input  logic              wr_en,
   input  logic [COL_W-1:0]  wr_col,
   input  logic [PAL_W-1:0]  wr_pal,
   input  logic [PIX_W-1:0]  wr_idx,
   input  logic              kangaroo,
   input  logic              wr_line_done,
   output logic              wr_ready,
   input  logic              line_start,
   input  logic [COL_W-1:0]  rd_col,
   output logic [CODE_W-1:0] rd_code,
   output logic              underflow,
   input  logic              clr_underflow
`ifdef MARIA_LRAM_COLLISION_EN
   ,
   output logic              collide,
   output logic              collide_line
`endif
);

   localparam logic [2:0] CNT_MAX = 3'(NUM_BANKS - 1);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [2:0]        count;
   logic              wr_accept;
   logic              commit;
   logic              rd_adv;
   logic [CODE_W-1:0] bank_rdata [NUM_BANKS];
   logic [CODE_W-1:0] rd_data_p0;
   logic [CODE_W-1:0] rd_code_p1;

   // The displayed bank is excluded explicitly, not only by the count limit.
   assign wr_ready  = (count < CNT_MAX) && (wr_ptr != rd_ptr);
   assign wr_accept = wr_en && wr_ready && ((wr_idx != '0) || kangaroo);
   assign commit    = wr_line_done && wr_ready;
   assign rd_adv    = line_start && (count != '0);

`ifdef MARIA_LRAM_COLLISION_EN
   logic [CODE_W-1:0] bank_old [NUM_BANKS];
   logic [CODE_W-1:0] wr_old;
`endif

   // Each bank is cleared wholesale as it leaves display on line_start, so a
   // bank reaching the write side again (or re-shown on underflow) is blank.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      maria_lram_bank #(
         .LINE_W (LINE_W),
         .CODE_W (CODE_W)
      ) u_bank (
         .clk     (sysclk),
         .rst_n   (reset_b),
         .clr_all (line_start && (rd_ptr == PTR_W'(b))),
         .we      (wr_accept && (wr_ptr == PTR_W'(b))),
         .wcol    (wr_col),
         .wdata   ({wr_pal, wr_idx}),
`ifdef MARIA_LRAM_COLLISION_EN
         .wr_old  (bank_old[b]),
`endif
         .re      (rd_ptr == PTR_W'(b)),
         .rcol    (rd_col),
         .rdata   (bank_rdata[b])
      );
   end

   always_comb begin
      rd_data_p0 = '0;
`ifdef MARIA_LRAM_COLLISION_EN
      wr_old     = '0;
`endif
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rd_ptr == PTR_W'(b))
            rd_data_p0 = bank_rdata[b];
`ifdef MARIA_LRAM_COLLISION_EN
         if (wr_ptr == PTR_W'(b))
            wr_old = bank_old[b];
`endif
      end
   end

   // Queue control: the decrement uses the pre-cycle count.
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr    <= '0;
         rd_ptr    <= PTR_W'(NUM_BANKS - 1);
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         if (commit)
            wr_ptr <= bank_inc(wr_ptr, NUM_BANKS);
         if (rd_adv)
            rd_ptr <= bank_inc(rd_ptr, NUM_BANKS);
         case ({commit, rd_adv})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (clr_underflow)
            underflow <= 1'b0;
         else if (line_start && (count == '0))
            underflow <= 1'b1;
      end
   end

   // p0 -> p1: registered playback code
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b)
         rd_code_p1 <= '0;
      else
         rd_code_p1 <= rd_data_p0;
   end

   assign rd_code = rd_code_p1;

`ifdef MARIA_LRAM_COLLISION_EN
   logic wr_hit;

   assign wr_hit = wr_accept && (wr_old[PIX_W-1:0] != '0);

   // A hit in the commit cycle still belongs to the line being committed.
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         collide      <= 1'b0;
         collide_line <= 1'b0;
      end else begin
         collide_line <= commit && (collide || wr_hit);
         if (commit)
            collide <= 1'b0;
         else if (wr_hit)
            collide <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_maria_lram_banked.sv
module tb_maria_lram_banked;

   localparam int LW = 320;

   logic       sysclk = 1'b0;
   logic       reset_b = 1'b1;
   logic       wr_en, kangaroo, wr_line_done, line_start, clr_underflow;
   logic [8:0] wr_col, rd_col;
   logic [2:0] wr_pal;
   logic [1:0] wr_idx;
   logic       wr_ready2, wr_ready3, underflow2, underflow3;
   logic [4:0] rd_code2, rd_code3;
`ifdef MARIA_LRAM_COLLISION_EN
   logic       collide2, collide3, collide_line2, collide_line3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sysclk = ~sysclk;

   maria_lram_banked #(.NUM_BANKS(2), .LINE_W(LW), .PIX_W(2), .PAL_W(3)) u2 (
      .sysclk(sysclk), .reset_b(reset_b), .wr_en(wr_en), .wr_col(wr_col),
      .wr_pal(wr_pal), .wr_idx(wr_idx), .kangaroo(kangaroo),
      .wr_line_done(wr_line_done), .wr_ready(wr_ready2), .line_start(line_start),
      .rd_col(rd_col), .rd_code(rd_code2), .underflow(underflow2),
      .clr_underflow(clr_underflow)
`ifdef MARIA_LRAM_COLLISION_EN
      , .collide(collide2), .collide_line(collide_line2)
`endif
   );

   maria_lram_banked #(.NUM_BANKS(3), .LINE_W(LW), .PIX_W(2), .PAL_W(3)) u3 (
      .sysclk(sysclk), .reset_b(reset_b), .wr_en(wr_en), .wr_col(wr_col),
      .wr_pal(wr_pal), .wr_idx(wr_idx), .kangaroo(kangaroo),
      .wr_line_done(wr_line_done), .wr_ready(wr_ready3), .line_start(line_start),
      .rd_col(rd_col), .rd_code(rd_code3), .underflow(underflow3),
      .clr_underflow(clr_underflow)
`ifdef MARIA_LRAM_COLLISION_EN
      , .collide(collide3), .collide_line(collide_line3)
`endif
   );

   // Reference model: index 0 models NUM_BANKS=2, index 1 models NUM_BANKS=3.
   logic [4:0] m_mem [2][4][LW];
   int         m_wp [2];
   int         m_rp [2];
   int         m_cnt[2];
   bit         m_uf [2];
   logic [4:0] m_rd [2];
   bit         m_col[2];
   bit         m_cl [2];

   function automatic bit m_wrdy(input int k);
      return (m_cnt[k] < (k + 2) - 1) && (m_wp[k] != m_rp[k]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < LW; c++)
               m_mem[k][b][c] = '0;
         m_wp[k] = 0; m_rp[k] = k + 1; m_cnt[k] = 0;
         m_uf[k] = 0; m_rd[k] = '0; m_col[k] = 0; m_cl[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int nb; bit wrdy, hit, commit, adv;
         nb = k + 2; wrdy = m_wrdy(k); hit = 0;
         if (rd_col < LW) begin
            m_rd[k] = m_mem[k][m_rp[k]][rd_col];
            m_mem[k][m_rp[k]][rd_col] = '0;
         end else begin
            m_rd[k] = '0;
         end
         if (wr_en && wrdy && (wr_idx != 0 || kangaroo) && wr_col < LW) begin
            hit = (m_mem[k][m_wp[k]][wr_col][1:0] != 0);
            m_mem[k][m_wp[k]][wr_col] = {wr_pal, wr_idx};
         end
         commit = wr_line_done && wrdy;
         adv    = line_start && (m_cnt[k] > 0);
         m_cl[k]  = commit && (m_col[k] || hit);
         m_col[k] = commit ? 1'b0 : (m_col[k] || hit);
         // A line leaving display is consumed whole; an underflow re-shows it blank.
         if (line_start)
            for (int c = 0; c < LW; c++) m_mem[k][m_rp[k]][c] = '0;
         if (clr_underflow) m_uf[k] = 0;
         else if (line_start && m_cnt[k] == 0) m_uf[k] = 1;
         m_cnt[k] = m_cnt[k] + int'(commit) - int'(adv);
         if (commit) m_wp[k] = (m_wp[k] + 1) % nb;
         if (adv)    m_rp[k] = (m_rp[k] + 1) % nb;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, " rd_code2"},   32'(rd_code2),   32'(m_rd[0]));
      check({tag, " rd_code3"},   32'(rd_code3),   32'(m_rd[1]));
      check({tag, " wr_ready2"},  32'(wr_ready2),  32'(m_wrdy(0)));
      check({tag, " wr_ready3"},  32'(wr_ready3),  32'(m_wrdy(1)));
      check({tag, " underflow2"}, 32'(underflow2), 32'(m_uf[0]));
      check({tag, " underflow3"}, 32'(underflow3), 32'(m_uf[1]));
`ifdef MARIA_LRAM_COLLISION_EN
      check({tag, " collide2"},   32'(collide2),      32'(m_col[0]));
      check({tag, " collide3"},   32'(collide3),      32'(m_col[1]));
      check({tag, " cline2"},     32'(collide_line2), 32'(m_cl[0]));
      check({tag, " cline3"},     32'(collide_line3), 32'(m_cl[1]));
`endif
   endtask

   task automatic set_idle();
      wr_en = 0; wr_col = '0; wr_pal = '0; wr_idx = '0; kangaroo = 0;
      wr_line_done = 0; line_start = 0; rd_col = 9'd400; clr_underflow = 0;
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge sysclk);
      @(negedge sysclk);
      compare_all(tag);
   endtask

   task automatic hard_reset(input string tag);
      @(negedge sysclk);
      #2 reset_b = 1'b0;
      #1;
      check({tag, " rst wr_ready2"},  32'(wr_ready2),  32'd1);
      check({tag, " rst wr_ready3"},  32'(wr_ready3),  32'd1);
      check({tag, " rst rd_code2"},   32'(rd_code2),   32'd0);
      check({tag, " rst rd_code3"},   32'(rd_code3),   32'd0);
      check({tag, " rst underflow2"}, 32'(underflow2), 32'd0);
      check({tag, " rst underflow3"}, 32'(underflow3), 32'd0);
      model_reset();
      set_idle();
      @(negedge sysclk);
      reset_b = 1'b1;
   endtask

   typedef struct {
      logic       we;  logic [8:0] col; logic [2:0] pal; logic [1:0] idx;
      logic       kang, done, ls;  logic [8:0] rcol; logic clr;
      logic [4:0] rd2, rd3; logic wr2, wr3, uf2, uf3;
   } vec_t;

   function automatic vec_t v(logic we, int col, int pal, int idx, logic kang,
                              logic done, logic ls, int rcol, logic clr,
                              int rd2, int rd3, logic wr2, logic wr3,
                              logic uf2, logic uf3);
      vec_t r;
      r.we = we; r.col = 9'(col); r.pal = 3'(pal); r.idx = 2'(idx); r.kang = kang;
      r.done = done; r.ls = ls; r.rcol = 9'(rcol); r.clr = clr;
      r.rd2 = 5'(rd2); r.rd3 = 5'(rd3); r.wr2 = wr2; r.wr3 = wr3; r.uf2 = uf2; r.uf3 = uf3;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [23];
      logic [4:0] first_code;

      set_idle();
      model_reset();
      #1 reset_b = 1'b0;
      @(negedge sysclk);
      @(negedge sysclk);
      check("reset wr_ready2",  32'(wr_ready2),  32'd1);
      check("reset wr_ready3",  32'(wr_ready3),  32'd1);
      check("reset rd_code2",   32'(rd_code2),   32'd0);
      check("reset rd_code3",   32'(rd_code3),   32'd0);
      check("reset underflow2", 32'(underflow2), 32'd0);
      check("reset underflow3", 32'(underflow3), 32'd0);
      reset_b = 1'b1;

      //            we col pal idx kg dn ls rcol clr  rd2 rd3 wr2 wr3 uf2 uf3
      tbl[0]  = v(1, 5,  3, 2, 0, 0, 0, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[1]  = v(1, 7,  1, 1, 0, 0, 0, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[2]  = v(1, 7,  2, 0, 0, 0, 0, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[3]  = v(0, 0,  0, 0, 0, 1, 0, 400, 0,   0,  0,  0, 1, 0, 0);
      tbl[4]  = v(0, 0,  0, 0, 0, 0, 1, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[5]  = v(0, 0,  0, 0, 0, 0, 0,   5, 0,  14, 14,  1, 1, 0, 0);
      tbl[6]  = v(0, 0,  0, 0, 0, 0, 0,   5, 0,   0,  0,  1, 1, 0, 0);
      tbl[7]  = v(0, 0,  0, 0, 0, 0, 0,   7, 0,   5,  5,  1, 1, 0, 0);
      tbl[8]  = v(1, 7,  1, 1, 0, 0, 0, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[9]  = v(1, 7,  2, 0, 1, 0, 0, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[10] = v(0, 0,  0, 0, 0, 1, 0, 400, 0,   0,  0,  0, 1, 0, 0);
      tbl[11] = v(0, 0,  0, 0, 0, 0, 1, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[12] = v(0, 0,  0, 0, 0, 0, 0,   7, 0,   8,  8,  1, 1, 0, 0);
      tbl[13] = v(0, 0,  0, 0, 0, 0, 1, 400, 0,   0,  0,  1, 1, 1, 1);
      tbl[14] = v(0, 0,  0, 0, 0, 0, 0,   5, 0,   0,  0,  1, 1, 1, 1);
      tbl[15] = v(0, 0,  0, 0, 0, 0, 0, 400, 1,   0,  0,  1, 1, 0, 0);
      tbl[16] = v(0, 0,  0, 0, 0, 0, 1, 400, 1,   0,  0,  1, 1, 0, 0);
      tbl[17] = v(0, 0,  0, 0, 0, 1, 0, 400, 0,   0,  0,  0, 1, 0, 0);
      tbl[18] = v(0, 0,  0, 0, 0, 1, 0, 400, 0,   0,  0,  0, 0, 0, 0);
      tbl[19] = v(0, 0,  0, 0, 0, 1, 0, 400, 0,   0,  0,  0, 0, 0, 0);
      tbl[20] = v(0, 0,  0, 0, 0, 0, 1, 400, 0,   0,  0,  1, 1, 0, 0);
      tbl[21] = v(0, 0,  0, 0, 0, 1, 1, 400, 0,   0,  0,  0, 1, 1, 0);
      tbl[22] = v(0, 0,  0, 0, 0, 1, 0, 400, 0,   0,  0,  0, 0, 1, 0);

      for (int i = 0; i < 23; i++) begin
         string t;
         t = $sformatf("row%0d", i);
         wr_en = tbl[i].we; wr_col = tbl[i].col; wr_pal = tbl[i].pal;
         wr_idx = tbl[i].idx; kangaroo = tbl[i].kang; wr_line_done = tbl[i].done;
         line_start = tbl[i].ls; rd_col = tbl[i].rcol; clr_underflow = tbl[i].clr;
         step(t);
         check({t, " tbl rd_code2"},   32'(rd_code2),   32'(tbl[i].rd2));
         check({t, " tbl rd_code3"},   32'(rd_code3),   32'(tbl[i].rd3));
         check({t, " tbl wr_ready2"},  32'(wr_ready2),  32'(tbl[i].wr2));
         check({t, " tbl wr_ready3"},  32'(wr_ready3),  32'(tbl[i].wr3));
         check({t, " tbl underflow2"}, 32'(underflow2), 32'(tbl[i].uf2));
         check({t, " tbl underflow3"}, 32'(underflow3), 32'(tbl[i].uf3));
      end

      // Asynchronous reset in the middle of a cycle, with underflow2 set.
      hard_reset("midline");

      // Partially displayed line followed by an underflow must read all zero.
      first_code = '0;
      for (int c = 0; c < 10; c++) begin
         set_idle();
         wr_en = 1; wr_col = 9'(c); wr_pal = 3'($urandom_range(0, 7));
         wr_idx = 2'($urandom_range(1, 3)); kangaroo = 1;
         if (c == 0) first_code = {wr_pal, wr_idx};
         step("fill");
      end
      set_idle(); wr_line_done = 1; step("commit");
      set_idle(); line_start = 1;   step("show");
      set_idle(); rd_col = 9'd0;    step("show col0");
      check("show col0 code2", 32'(rd_code2), 32'(first_code));
      check("show col0 code3", 32'(rd_code3), 32'(first_code));
      set_idle(); line_start = 1;   step("uflow");
      check("uflow flag2", 32'(underflow2), 32'd1);
      check("uflow flag3", 32'(underflow3), 32'd1);
      for (int c = 0; c < LW; c++) begin
         set_idle(); rd_col = 9'(c); step("sweep");
         check("sweep zero2", 32'(rd_code2), 32'd0);
         check("sweep zero3", 32'(rd_code3), 32'd0);
      end
      set_idle(); clr_underflow = 1; step("clr");
      check("clr flag2", 32'(underflow2), 32'd0);

`ifdef MARIA_LRAM_COLLISION_EN
      hard_reset("coll");
      set_idle(); wr_en = 1; wr_col = 9'd10; wr_pal = 3'd1; wr_idx = 2'd1; step("coll w1");
      set_idle(); wr_en = 1; wr_col = 9'd10; wr_pal = 3'd2; wr_idx = 2'd2; step("coll w2");
      check("coll sticky2", 32'(collide2), 32'd1);
      set_idle(); wr_line_done = 1; step("coll done");
      check("coll line2", 32'(collide_line2), 32'd1);
      check("coll line3", 32'(collide_line3), 32'd1);
      set_idle(); step("coll after");
      check("coll pulse2", 32'(collide_line2), 32'd0);
      set_idle(); line_start = 1; step("coll ls");
      set_idle(); wr_en = 1; wr_col = 9'd10; wr_idx = 2'd1; step("clean w1");
      set_idle(); wr_en = 1; wr_col = 9'd11; wr_idx = 2'd1; step("clean w2");
      set_idle(); wr_line_done = 1; step("clean done");
      check("clean line2", 32'(collide_line2), 32'd0);
      check("clean line3", 32'(collide_line3), 32'd0);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         wr_en         = ($urandom_range(0, 99) < 60);
         wr_col        = ($urandom_range(0, 99) < 85) ? 9'($urandom_range(0, 15))
                                                      : 9'($urandom_range(0, 511));
         wr_pal        = 3'($urandom_range(0, 7));
         wr_idx        = 2'($urandom_range(0, 3));
         kangaroo      = ($urandom_range(0, 1) == 1);
         wr_line_done  = ($urandom_range(0, 11) == 0);
         line_start    = ($urandom_range(0, 9) == 0);
         rd_col        = ($urandom_range(0, 99) < 85) ? 9'($urandom_range(0, 15))
                                                      : 9'($urandom_range(0, 511));
         clr_underflow = ($urandom_range(0, 19) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
